// File: rtl/instr_mem_pkg.sv
// Shared widths and requester indices for the instruction-memory arbiter.
package instr_mem_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NUM_REQ = 3;

  typedef logic [1:0] req_idx_t;

  localparam req_idx_t FETCH = 2'd0;
  localparam req_idx_t LOAD  = 2'd1;
  localparam req_idx_t DBG   = 2'd2;

  // Next requester in round-robin order FETCH -> LOAD -> DBG -> FETCH.
  function automatic req_idx_t rr_next(input req_idx_t idx);
    return (idx == DBG) ? FETCH : req_idx_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/instr_ram.sv
// 256x8 single-port RAM: synchronous write, registered read, no reset on contents.
module instr_ram
  import instr_mem_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];
  logic [DATA_W-1:0] rdata_q;

  // One access per cycle: either commit a write or capture a read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_arbiter.sv
// Round-robin arbiter sharing one instruction RAM between fetch, loader and debug ports.
module instr_mem_arbiter
  import instr_mem_pkg::*;
(
  input  logic              clk_50m,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              cpu_stall,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_gnt,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] gnt_vec;
  req_idx_t           cand;
  req_idx_t           gnt_idx;
  req_idx_t           last_gnt_q;

  logic               fetch_rvalid_q;
  logic               dbg_rvalid_q;
  logic [DATA_W-1:0]  fetch_hold_q;
  logic [DATA_W-1:0]  dbg_hold_q;

  logic               ram_we;
  logic               ram_re;
  logic [ADDR_W-1:0]  ram_addr;
  logic [DATA_W-1:0]  ram_rdata;

  // Round-robin search starting just after the last granted requester.
  // Grants are forced low while reset is held so no write slips in.
  always_comb begin
    req_vec = {dbg_req, load_req, fetch_req};
    gnt_vec = '0;
    gnt_idx = last_gnt_q;
    cand    = last_gnt_q;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      cand = rr_next(cand);
      if (gnt_vec == '0 && req_vec[cand] && reset) begin
        gnt_vec[cand] = 1'b1;
        gnt_idx       = cand;
      end
    end
  end

  assign fetch_gnt = gnt_vec[FETCH];
  assign load_gnt  = gnt_vec[LOAD];
  assign dbg_gnt   = gnt_vec[DBG];
  assign cpu_stall = fetch_req & ~fetch_gnt;

  // RAM port mux: at most one grant is ever active.
  always_comb begin
    ram_we   = load_gnt;
    ram_re   = fetch_gnt | dbg_gnt;
    ram_addr = dbg_addr;
    if (fetch_gnt) begin
      ram_addr = fetch_addr;
    end else if (load_gnt) begin
      ram_addr = load_addr;
    end
  end

  instr_ram u_ram (
    .clk   (clk_50m),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  // Arbiter state, per-port read tags and held read data.
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      last_gnt_q     <= DBG;
      fetch_rvalid_q <= 1'b0;
      dbg_rvalid_q   <= 1'b0;
      fetch_hold_q   <= '0;
      dbg_hold_q     <= '0;
    end else begin
      if (|gnt_vec) begin
        last_gnt_q <= gnt_idx;
      end
      fetch_rvalid_q <= fetch_gnt;
      dbg_rvalid_q   <= dbg_gnt;
      if (fetch_rvalid_q) begin
        fetch_hold_q <= ram_rdata;
      end
      if (dbg_rvalid_q) begin
        dbg_hold_q <= ram_rdata;
      end
    end
  end

  // Fresh RAM data on the valid cycle, otherwise the last delivered byte.
  assign fetch_rvalid = fetch_rvalid_q;
  assign dbg_rvalid   = dbg_rvalid_q;
  assign fetch_instr  = fetch_rvalid_q ? ram_rdata : fetch_hold_q;
  assign dbg_data     = dbg_rvalid_q ? ram_rdata : dbg_hold_q;

endmodule

// File: doc/instr_mem_arbiter.md
INSTR_MEM_ARBITER -- requirements
Module: instr_mem_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed as name, direction, width, meaning.
REQ-002 clk_50m  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 fetch_req  in  1  processor instruction-fetch request.
REQ-005 fetch_addr  in  8  fetch address (pc).
REQ-006 fetch_gnt  out  1  fetch accepted this cycle.
REQ-007 fetch_rvalid  out  1  fetch_instr valid (one-cycle pulse).
REQ-008 fetch_instr  out  8  fetched instruction byte.
REQ-009 cpu_stall  out  1  fetch_req high and fetch_gnt low.
REQ-010 load_req  in  1  program-loader write request.
REQ-011 load_addr  in  8  write address.
REQ-012 load_data  in  8  write data.
REQ-013 load_gnt  out  1  write accepted (committed) this cycle.
REQ-014 dbg_req  in  1  test/debug read request.
REQ-015 dbg_addr  in  8  debug read address (test_pc).
REQ-016 dbg_gnt  out  1  debug read accepted this cycle.
REQ-017 dbg_rvalid  out  1  dbg_data valid (one-cycle pulse).
REQ-018 dbg_data  out  8  debug read byte (test_instruction).

Function
REQ-019 The block SHALL own one 256x8 single-port synchronous RAM and grant at most one requester per cycle.
REQ-020 Requesters SHALL hold req, addr and data stable until their gnt; gnt is combinational from req and arbiter state in the same cycle.
REQ-021 Arbitration SHALL be round-robin over order FETCH -> LOAD -> DBG, with search starting at the requester after last_gnt.
REQ-022 last_gnt SHALL update only on a cycle with a grant; with no requests, no gnt asserts and last_gnt holds.
REQ-023 A granted write SHALL commit load_data at load_addr on that clock edge.
REQ-024 A granted read SHALL drive data and the matching rvalid exactly one cycle after gnt (latency 1); fetch_instr/dbg_data hold their last value otherwise.
REQ-025 A read granted the cycle after a write to the same address SHALL return the new data.
REQ-026 With all three requesting continuously, grants SHALL rotate FETCH, LOAD, DBG, FETCH...; no requester waits more than 2 cycles.
REQ-027 Back-to-back grants to the same requester SHALL be allowed when it is the only one requesting (one access per cycle, full throughput).
REQ-028 cpu_stall SHALL equal fetch_req AND NOT fetch_gnt, combinationally.
REQ-029 Addresses SHALL be 8-bit unsigned; 0xFF is valid, no wrap logic is internal.

Reset
REQ-030 While reset=0: all gnt, rvalid and cpu_stall (modulo fetch_req) outputs 0; fetch_instr=0x00, dbg_data=0x00; last_gnt=DBG, so FETCH has first priority.
REQ-031 Reset SHALL cancel any in-flight read (no rvalid after reset release); RAM contents are not reset and are preserved across reset.
REQ-032 A write granted in the same cycle reset asserts SHALL NOT be guaranteed; loader re-issues it.

Structure
REQ-033 Shared package instr_mem_pkg SHALL hold ADDR_W=8, DATA_W=8 and the requester-index constants FETCH=0, LOAD=1, DBG=2.
REQ-034 RAM SHALL be a sub-module instr_ram (256x8, sync write, registered read); arbiter, read-tag register and output registers live in instr_mem_arbiter.

Verification
REQ-035 Reset then fetch_req at addr 0x00 alone -> fetch_gnt same cycle, fetch_rvalid next cycle, cpu_stall=0 throughout.
REQ-036 load 0xA5@0x10 then fetch 0x10 in next cycle -> fetch_instr=0xA5 one cycle after fetch_gnt.
REQ-037 All three request continuously for 6 cycles -> grant sequence FETCH, LOAD, DBG, FETCH, LOAD, DBG; cpu_stall high on the 4 non-fetch cycles.
REQ-038 load 0x3C@0xFF, dbg read 0xFF -> dbg_rvalid with dbg_data=0x3C; fetch_rvalid stays 0.
REQ-039 Assert reset the cycle after a dbg_gnt -> dbg_rvalid never pulses; after release, previous RAM writes read back unchanged and FETCH wins first contention.
